// File: rtl/priv_1_12_perf_counters_pkg.sv
// Shared types, CSR addresses and counter-slot helpers for the Zicntr/Zihpm counter unit.
package priv_1_12_perf_counters_pkg;

  typedef enum logic [1:0] {
    U_MODE    = 2'b00,
    S_MODE    = 2'b01,
    RSVD_MODE = 2'b10,
    M_MODE    = 2'b11
  } priv_level_t;

  localparam logic [11:0] MCYCLE        = 12'hB00;
  localparam logic [11:0] MCYCLEH       = 12'hB80;
  localparam logic [11:0] MINSTRET      = 12'hB02;
  localparam logic [11:0] MINSTRETH     = 12'hB82;
  localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] MHPMEVENT3    = 12'h323;
  localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] MCOUNTEREN    = 12'h306;
  localparam logic [11:0] CYCLE         = 12'hC00;
  localparam logic [11:0] CYCLEH        = 12'hC80;

  // Raw mhpmevent code as seen on the CSR bus before WARL legalisation.
  typedef logic [4:0] hpm_event_t;

  // Counter indices that physically exist: cycle (0), instret (2), hpm3..3+num_hpm-1.
  function automatic logic [31:0] impl_mask(int num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < 29; i++) begin
      if (i < num_hpm) m[3+i] = 1'b1;
    end
    return m;
  endfunction

  // Counter slot s -> CSR index: slot 0 is mcycle, slot 1 is minstret, slot 2.. are hpm3..
  function automatic logic [4:0] slot_idx(int s);
    return (s == 0) ? 5'd0 : 5'(s + 1);
  endfunction

endpackage

// File: rtl/priv_1_12_perf_counters_if.sv
// CSR access bus between the CSR file (master) and the counter unit (slave).
interface priv_1_12_perf_counters_if;
  import priv_1_12_perf_counters_pkg::*;

  priv_level_t curr_priv;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        csr_illegal;

  modport master (
    output curr_priv, csr_addr, csr_wen, csr_wdata,
    input  csr_rdata, csr_hit, csr_illegal
  );

  modport slave (
    input  curr_priv, csr_addr, csr_wen, csr_wdata,
    output csr_rdata, csr_hit, csr_illegal
  );

endinterface

// File: rtl/priv_1_12_hpm_counter.sv
// One performance counter: event select, inhibit, per-half write and sticky wrap flag.
module priv_1_12_hpm_counter #(
  parameter int  COUNTER_WIDTH = 64,
  parameter int  NUM_EVENTS    = 8,
  localparam int EW            = $clog2(NUM_EVENTS + 1)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [EW-1:0]            event_i,
  input  logic [NUM_EVENTS-1:0]    event_vec_i,
  input  logic                     inhibit_i,
  input  logic                     wr_lo_i,
  input  logic                     wr_hi_i,
  input  logic [31:0]              wdata_i,
  output logic [COUNTER_WIDTH-1:0] count_o,
  output logic                     ovf_o
);

  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     fire, inc;

  always_comb begin
    fire = 1'b0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      if (event_i == EW'(e + 1) && event_vec_i[e]) fire = 1'b1;
    end
  end

  assign inc = fire & ~inhibit_i & ~wr_lo_i & ~wr_hi_i;

  // A CSR write always wins over the count and clears the wrap flag.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0] = wdata_i;
      if (wr_hi_i) count_d[COUNTER_WIDTH-1:32] = wdata_i[COUNTER_WIDTH-33:0];
      ovf_d = 1'b0;
    end else if (inc) begin
      count_d = count_q + COUNTER_WIDTH'(1);
      if (&count_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/priv_1_12_perf_counters.sv
// RV32 Zicntr/Zihpm counter unit: CSR decode, access checks, control registers and read mux.
module priv_1_12_perf_counters
  import priv_1_12_perf_counters_pkg::*;
#(
  parameter int NUM_HPM       = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 8
) (
  input  logic                          CLK,
  input  logic                          nRST,
  priv_1_12_perf_counters_if.slave      csr,
  input  logic                          inst_ret,
  input  logic [NUM_EVENTS-1:0]         event_vec,
  output logic [NUM_HPM-1:0]            hpm_ovf
);

  localparam int          EW    = $clog2(NUM_EVENTS + 1);
  localparam int          NSLOT = NUM_HPM + 2;
  localparam logic [31:0] IMPL  = impl_mask(NUM_HPM);

  logic [31:0]              mcounteren_q, mcounteren_d;
  logic [31:0]              mcountinhibit_q, mcountinhibit_d;
  logic [EW-1:0]            event_q [NUM_HPM];
  logic [EW-1:0]            event_d [NUM_HPM];
  logic [COUNTER_WIDTH-1:0] cnt_w [NSLOT];
  logic                     ovf_w [NSLOT];
  logic [NSLOT-1:0]         wr_lo, wr_hi;

  logic [4:0]  idx;
  logic        hi_half, ctr_m, ctr_u, is_evt, is_inh, is_en, hit, illegal, wr_ok;
  logic [63:0] ctr_val;
  logic [31:0] evt_val, rdata;

  always_comb begin
    idx     = csr.csr_addr[4:0];
    hi_half = csr.csr_addr[7];
    ctr_m   = (csr.csr_addr[11:5] == MCYCLE[11:5]) || (csr.csr_addr[11:5] == MCYCLEH[11:5]);
    ctr_u   = (csr.csr_addr[11:5] == CYCLE[11:5])  || (csr.csr_addr[11:5] == CYCLEH[11:5]);
    is_evt  = (csr.csr_addr[11:5] == MCOUNTINHIBIT[11:5]) && (idx >= 5'd3);
    is_inh  = (csr.csr_addr == MCOUNTINHIBIT);
    is_en   = (csr.csr_addr == MCOUNTEREN);
    hit     = ((ctr_m || ctr_u || is_evt) && IMPL[idx]) || is_inh || is_en;

    ctr_val = '0;
    for (int s = 0; s < NSLOT; s++) begin
      if (idx == slot_idx(s)) ctr_val = 64'(cnt_w[s]);
    end
    evt_val = '0;
    for (int h = 0; h < NUM_HPM; h++) begin
      if (idx == slot_idx(h + 2)) evt_val = 32'(event_q[h]);
    end

    // User aliases are read-only and gated by mcounteren below M-mode.
    illegal = 1'b0;
    if (hit) begin
      if (ctr_u) illegal = csr.csr_wen || (csr.curr_priv != M_MODE && !mcounteren_q[idx]);
      else       illegal = (csr.curr_priv != M_MODE);
    end

    rdata = '0;
    if (hit && !illegal) begin
      if (ctr_m || ctr_u) rdata = hi_half ? ctr_val[63:32] : ctr_val[31:0];
      else if (is_evt)    rdata = evt_val;
      else if (is_inh)    rdata = mcountinhibit_q;
      else                rdata = mcounteren_q;
    end

    wr_ok = csr.csr_wen && hit && !illegal;
  end

  assign csr.csr_rdata   = rdata;
  assign csr.csr_hit     = hit;
  assign csr.csr_illegal = illegal;

  always_comb begin
    mcounteren_d    = mcounteren_q;
    mcountinhibit_d = mcountinhibit_q;
    event_d         = event_q;
    wr_lo           = '0;
    wr_hi           = '0;
    if (wr_ok) begin
      if (is_en)  mcounteren_d    = csr.csr_wdata & IMPL;
      if (is_inh) mcountinhibit_d = csr.csr_wdata & IMPL;
      for (int h = 0; h < NUM_HPM; h++) begin
        if (is_evt && idx == slot_idx(h + 2))
          event_d[h] = (csr.csr_wdata <= 32'(NUM_EVENTS)) ? csr.csr_wdata[EW-1:0] : '0;
      end
      for (int s = 0; s < NSLOT; s++) begin
        if (ctr_m && idx == slot_idx(s)) begin
          wr_lo[s] = !hi_half;
          wr_hi[s] = hi_half;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mcounteren_q    <= '0;
      mcountinhibit_q <= '0;
      for (int h = 0; h < NUM_HPM; h++) event_q[h] <= '0;
    end else begin
      mcounteren_q    <= mcounteren_d;
      mcountinhibit_q <= mcountinhibit_d;
      event_q         <= event_d;
    end
  end

  // mcycle and minstret reuse the generic counter with a permanently selected event 1.
  for (genvar s = 0; s < NSLOT; s++) begin : g_ctr
    logic [EW-1:0]         code;
    logic [NUM_EVENTS-1:0] vec;
    if (s == 0) begin : g_cycle
      assign code = EW'(1);
      assign vec  = '1;
    end else if (s == 1) begin : g_instret
      assign code = EW'(1);
      assign vec  = {NUM_EVENTS{inst_ret}};
    end else begin : g_hpm
      assign code = event_q[s-2];
      assign vec  = event_vec;
    end

    priv_1_12_hpm_counter #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .NUM_EVENTS    (NUM_EVENTS)
    ) u_ctr (
      .CLK         (CLK),
      .nRST        (nRST),
      .event_i     (code),
      .event_vec_i (vec),
      .inhibit_i   (mcountinhibit_q[slot_idx(s)]),
      .wr_lo_i     (wr_lo[s]),
      .wr_hi_i     (wr_hi[s]),
      .wdata_i     (csr.csr_wdata),
      .count_o     (cnt_w[s]),
      .ovf_o       (ovf_w[s])
    );
  end

  for (genvar h = 0; h < NUM_HPM; h++) begin : g_ovf
    assign hpm_ovf[h] = ovf_w[h+2];
  end

endmodule

// File: tb/tb_priv_1_12_perf_counters.sv
// Bench for the counter unit: directed scenarios plus random CSR traffic against an array model.
module tb_priv_1_12_perf_counters;
  import priv_1_12_perf_counters_pkg::*;

  localparam int NH = 4;
  localparam int CW = 64;
  localparam int NE = 8;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          inst_ret;
  logic [NE-1:0] event_vec;
  logic [NH-1:0] hpm_ovf;

  priv_1_12_perf_counters_if csr_bus();

  priv_1_12_perf_counters #(.NUM_HPM(NH), .COUNTER_WIDTH(CW), .NUM_EVENTS(NE)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .csr       (csr_bus),
    .inst_ret  (inst_ret),
    .event_vec (event_vec),
    .hpm_ovf   (hpm_ovf)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  longint unsigned m_cnt [32];
  bit              m_ovf [32];
  int              m_evt [32];
  logic [31:0]     m_inh, m_en;

  logic [11:0] addr_tab [21] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB06,
                                 12'hB86, 12'hB07, 12'hC00, 12'hC82, 12'hC03, 12'hC86, 12'h323,
                                 12'h324, 12'h326, 12'h327, 12'h320, 12'h306, 12'h321, 12'h123};

  function automatic bit implemented(int k);
    return (k == 0) || (k == 2) || (k >= 3 && k < 3 + NH);
  endfunction

  function automatic void model_read(input int a, input int priv, input bit wen,
                                     output bit hit, output bit ill, output logic [31:0] rd);
    int k;
    bit ctr, user, hi;
    logic [31:0] val;
    k    = a % 32;
    ctr  = (a >= 'hB00 && a < 'hB20) || (a >= 'hB80 && a < 'hBA0) ||
           (a >= 'hC00 && a < 'hC20) || (a >= 'hC80 && a < 'hCA0);
    user = (a >= 'hC00);
    hi   = (a % 256) >= 128;
    hit  = 1'b0;
    val  = '0;
    if (ctr && implemented(k)) begin
      hit = 1'b1;
      val = hi ? 32'(m_cnt[k] >> 32) : 32'(m_cnt[k]);
    end else if (a >= 'h323 && a < 'h340 && implemented(k)) begin
      hit = 1'b1;
      val = 32'(m_evt[k]);
    end else if (a == 'h320) begin
      hit = 1'b1;
      val = m_inh;
    end else if (a == 'h306) begin
      hit = 1'b1;
      val = m_en;
    end
    ill = 1'b0;
    if (hit) ill = user ? (wen || (priv != 3 && !m_en[k])) : (priv != 3);
    rd = (hit && !ill) ? val : 32'h0;
  endfunction

  function automatic void model_update(input int a, input bit wen, input logic [31:0] wd,
                                       input int priv, input bit ir, input logic [NE-1:0] ev);
    bit hit, ill, wr, fire;
    logic [31:0] rd, imask;
    model_read(a, priv, wen, hit, ill, rd);
    wr    = wen && hit && !ill;
    imask = '0;
    for (int j = 0; j < 32; j++) if (implemented(j)) imask[j] = 1'b1;
    for (int j = 0; j < 32; j++) begin
      if (implemented(j)) begin
        if (j == 0)      fire = 1'b1;
        else if (j == 2) fire = ir;
        else             fire = (m_evt[j] >= 1 && m_evt[j] <= NE) ? ev[m_evt[j]-1] : 1'b0;
        if (wr && (a == 'hB00 + j || a == 'hB80 + j)) begin
          if (a < 'hB80) m_cnt[j] = (m_cnt[j] & 64'hFFFF_FFFF_0000_0000) | 64'(wd);
          else           m_cnt[j] = (m_cnt[j] & 64'h0000_0000_FFFF_FFFF) | (64'(wd) << 32);
          m_ovf[j] = 1'b0;
        end else if (!m_inh[j] && fire) begin
          m_cnt[j] = m_cnt[j] + 1;
          if (m_cnt[j] == 0 && j >= 3) m_ovf[j] = 1'b1;
        end
      end
    end
    if (wr) begin
      if (a == 'h320)                  m_inh = wd & imask;
      else if (a == 'h306)             m_en  = wd & imask;
      else if (a >= 'h323 && a < 'h340) m_evt[a % 32] = (wd <= NE) ? int'(wd) : 0;
    end
  endfunction

  function automatic logic [NH-1:0] model_ovf();
    logic [NH-1:0] v;
    for (int h = 0; h < NH; h++) v[h] = m_ovf[h+3];
    return v;
  endfunction

  task automatic drive(input logic [11:0] a, input bit wen, input logic [31:0] wd,
                       input priv_level_t p, input bit ir, input logic [NE-1:0] ev);
    csr_bus.csr_addr  = a;
    csr_bus.csr_wen   = wen;
    csr_bus.csr_wdata = wd;
    csr_bus.curr_priv = p;
    inst_ret          = ir;
    event_vec         = ev;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update(int'(csr_bus.csr_addr), csr_bus.csr_wen, csr_bus.csr_wdata,
                 int'(csr_bus.curr_priv), inst_ret, event_vec);
    #1;
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
    drive(a, 1'b1, d, M_MODE, 1'b0, '0);
    tick();
    drive(a, 1'b0, 32'h0, M_MODE, 1'b0, '0);
  endtask

  task automatic sample(input logic [11:0] a, input priv_level_t p, input bit wen,
                        output logic [31:0] got, output logic [31:0] exp,
                        output logic ghit, output logic gill, output bit ehit, output bit eill);
    drive(a, wen, 32'h0, p, 1'b0, '0);
    #1;
    got  = csr_bus.csr_rdata;
    ghit = csr_bus.csr_hit;
    gill = csr_bus.csr_illegal;
    model_read(int'(a), int'(p), wen, ehit, eill, exp);
  endtask

  task automatic test_reset();
    logic [31:0] g, e; logic gh, gi; bit eh, ei;
    nRST = 1'b0;
    drive(12'h000, 1'b0, 32'h0, M_MODE, 1'b0, '0);
    for (int k = 0; k < 32; k++) begin
      m_cnt[k] = 0; m_ovf[k] = 1'b0; m_evt[k] = 0;
    end
    m_inh = '0; m_en = '0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    sample(12'hB00, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd0 || gh !== 1'b1) begin errors++; $display("FAIL reset_mcycle got %h hit %b exp 0 hit 1", g, gh); end
    checks++; if (hpm_ovf !== '0) begin errors++; $display("FAIL reset_ovf got %b exp 0", hpm_ovf); end
    sample(12'h123, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (gh !== 1'b0 || gi !== 1'b0 || g !== 32'd0) begin errors++; $display("FAIL reset_unmapped got hit %b ill %b rd %h exp 0 0 0", gh, gi, g); end
  endtask

  task automatic test_idle();
    logic [31:0] g, e; logic gh, gi; bit eh, ei;
    repeat (10) tick();
    sample(12'hB00, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd10 || g !== e) begin errors++; $display("FAIL idle_mcycle got %0d exp 10 model %0d", g, e); end
    sample(12'hB02, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd0) begin errors++; $display("FAIL idle_minstret got %0d exp 0", g); end
  endtask

  task automatic test_carry();
    logic [31:0] g, e; logic gh, gi; bit eh, ei;
    wr_csr(12'hB00, 32'hFFFF_FFFF);
    wr_csr(12'hB80, 32'h0);
    tick();
    sample(12'hB80, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd1 || g !== e) begin errors++; $display("FAIL carry_mcycleh got %h exp 1 model %h", g, e); end
    sample(12'hB00, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd0 || g !== e) begin errors++; $display("FAIL carry_mcycle got %h exp 0 model %h", g, e); end
  endtask

  task automatic test_event_inhibit();
    logic [31:0] g, e; logic gh, gi; bit eh, ei;
    wr_csr(12'h323, 32'd2);
    repeat (3) begin
      drive(12'hB03, 1'b0, 32'h0, M_MODE, 1'b0, 8'h02);
      tick();
    end
    wr_csr(12'h320, 32'h8);
    repeat (2) begin
      drive(12'hB03, 1'b0, 32'h0, M_MODE, 1'b0, 8'h02);
      tick();
    end
    sample(12'hB03, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd3 || g !== e) begin errors++; $display("FAIL event_inhibit got %0d exp 3 model %0d", g, e); end
    wr_csr(12'h320, 32'h0);
  endtask

  task automatic test_overflow();
    logic [31:0] g, e; logic gh, gi; bit eh, ei;
    wr_csr(12'hB03, 32'hFFFF_FFFF);
    wr_csr(12'hB83, 32'hFFFF_FFFF);
    drive(12'hB03, 1'b0, 32'h0, M_MODE, 1'b0, 8'h02);
    tick();
    sample(12'hB03, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd0) begin errors++; $display("FAIL wrap_lo got %h exp 0", g); end
    sample(12'hB83, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd0) begin errors++; $display("FAIL wrap_hi got %h exp 0", g); end
    checks++; if (hpm_ovf !== 4'b0001) begin errors++; $display("FAIL wrap_ovf got %b exp 0001", hpm_ovf); end
    wr_csr(12'hB03, 32'd7);
    sample(12'hB03, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd7 || hpm_ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clear got %h ovf %b exp 7 ovf 0000", g, hpm_ovf); end
    wr_csr(12'hB03, 32'hFFFF_FFFF);
    wr_csr(12'hB83, 32'hFFFF_FFFF);
    drive(12'hB83, 1'b1, 32'hFFFF_FFFF, M_MODE, 1'b0, 8'h02);
    tick();
    sample(12'hB03, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'hFFFF_FFFF || hpm_ovf !== 4'b0000) begin errors++; $display("FAIL write_beats_wrap got %h ovf %b exp ffffffff ovf 0000", g, hpm_ovf); end
  endtask

  task automatic test_user_access();
    logic [31:0] g, e; logic gh, gi; bit eh, ei;
    repeat (3) begin
      drive(12'h000, 1'b0, 32'h0, M_MODE, 1'b1, '0);
      tick();
    end
    sample(12'hC02, U_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (gi !== 1'b1 || g !== 32'd0 || gh !== 1'b1) begin errors++; $display("FAIL user_denied got ill %b rd %h hit %b exp 1 0 1", gi, g, gh); end
    sample(12'hB00, S_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (gi !== 1'b1 || g !== 32'd0) begin errors++; $display("FAIL mrange_smode got ill %b rd %h exp 1 0", gi, g); end
    sample(12'hB1F, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (gh !== 1'b0 || gi !== 1'b0) begin errors++; $display("FAIL unimpl_ctr got hit %b ill %b exp 0 0", gh, gi); end
    wr_csr(12'h306, 32'h4);
    sample(12'hC02, U_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (gi !== 1'b0 || g !== 32'd3 || g !== e) begin errors++; $display("FAIL user_allowed got ill %b rd %0d exp 0 3 model %0d", gi, g, e); end
    sample(12'hC00, U_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (gi !== 1'b1) begin errors++; $display("FAIL user_cycle_gated got ill %b exp 1", gi); end
    sample(12'hC00, M_MODE, 1'b1, g, e, gh, gi, eh, ei);
    checks++; if (gi !== 1'b1 || g !== 32'd0) begin errors++; $display("FAIL alias_write got ill %b rd %h exp 1 0", gi, g); end
    tick();
    sample(12'hB00, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== e) begin errors++; $display("FAIL alias_write_blocked got %h exp %h", g, e); end
  endtask

  task automatic test_write_priority();
    logic [31:0] g, e; logic gh, gi; bit eh, ei;
    drive(12'hB02, 1'b1, 32'd100, M_MODE, 1'b1, '0);
    tick();
    sample(12'hB02, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd100) begin errors++; $display("FAIL write_over_instret got %0d exp 100", g); end
    wr_csr(12'h324, 32'd99);
    sample(12'h324, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd0) begin errors++; $display("FAIL event_warl_99 got %0d exp 0", g); end
    wr_csr(12'h324, 32'd8);
    sample(12'h324, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'd8) begin errors++; $display("FAIL event_warl_8 got %0d exp 8", g); end
    wr_csr(12'h320, 32'hFFFF_FFFF);
    sample(12'h320, M_MODE, 1'b0, g, e, gh, gi, eh, ei);
    checks++; if (g !== 32'h0000_007D) begin errors++; $display("FAIL inhibit_mask got %h exp 0000007d", g); end
    wr_csr(12'h320, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] g, e, wd; logic gh, gi; bit eh, ei, wen;
    logic [11:0] a;
    priv_level_t p;
    for (int i = 0; i < 400; i++) begin
      a   = addr_tab[$urandom_range(0, 20)];
      wen = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       wd = 32'hFFFF_FFFF;
        1:       wd = 32'hFFFF_FFF0;
        2:       wd = 32'($urandom_range(0, 12));
        default: wd = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       p = U_MODE;
        1:       p = S_MODE;
        default: p = M_MODE;
      endcase
      drive(a, wen, wd, p, 1'($urandom_range(0, 1)), NE'($urandom));
      #1;
      g  = csr_bus.csr_rdata;
      gh = csr_bus.csr_hit;
      gi = csr_bus.csr_illegal;
      model_read(int'(a), int'(p), wen, eh, ei, e);
      checks++;
      if (g !== e || gh !== eh || gi !== ei || hpm_ovf !== model_ovf()) begin
        errors++;
        $display("FAIL random[%0d] addr %h got rd %h hit %b ill %b ovf %b exp rd %h hit %b ill %b ovf %b",
                 i, a, g, gh, gi, hpm_ovf, e, eh, ei, model_ovf());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_carry();
    test_event_inhibit();
    test_overflow();
    test_user_access();
    test_write_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
